dram_cmd_shim: RTL
==================

Name: dram_cmd_shim

Overview:
- Sits between TinyORAMCore's DRAM-side interface and DDR3SDRAM_mig7 in each board top.
- Decouples write data from write commands through a write-data FIFO and enforces the MIG rule that write data precedes or accompanies its command.
- Throttles reads against an outstanding-read limit and forwards read data back to the core.
- Blocks all commands until DRAM calibration completes.

Parameters:
- DDRCWidth, 3: command width; Write = 3'b000, Read = 3'b001.
- DDRAWidth, 28: DRAM address width.
- DDRDWidth, 512: data beat width; one beat per command.
- DDRMWidth, 64: write mask width (DDRDWidth/8).
- WrFIFODepth, 16: write-data FIFO entries; power of 2.
- MaxOutReads, 32: maximum read commands issued but not yet returned.

Ports:
- Clock  in  1  single clock domain (ORAMClock).
- ResetN  in  1  asynchronous, active-low reset.
- CalibrationComplete  in  1  from the MIG.
- UpCommand  in  DDRCWidth; UpAddress  in  DDRAWidth; UpCommandValid  in  1; UpCommandReady  out  1: command from the core.
- UpWriteData  in  DDRDWidth; UpWriteMask  in  DDRMWidth; UpWriteDataValid  in  1; UpWriteDataReady  out  1: write data from the core.
- UpReadData  out  DDRDWidth; UpReadDataValid  out  1: read return to the core. There is no ready; the core always accepts.
- DRAMCommand  out  DDRCWidth; DRAMAddress  out  DDRAWidth; DRAMCommandValid  out  1; DRAMCommandReady  in  1: command to the MIG.
- DRAMWriteData  out  DDRDWidth; DRAMWriteMask  out  DDRMWidth; DRAMWriteDataValid  out  1; DRAMWriteDataReady  in  1: write data to the MIG.
- DRAMReadData  in  DDRDWidth; DRAMReadDataValid  in  1: read data from the MIG.
- OutReads  out  log2(MaxOutReads)+1  current outstanding-read count.
- ErrorReadUnderflow  out  1  sticky error flag.

Behaviour:
- Reset (ResetN low, asynchronous):
  - All valids, Ready outputs, OutReads and ErrorReadUnderflow go to 0.
  - FIFO is emptied; write credit count is 0; FSM enters WAIT_CAL.
  - Data registers are don't-care.
- FSM states:
  - WAIT_CAL -> RUN when CalibrationComplete = 1.
  - RUN -> HALT when CalibrationComplete falls.
  - HALT -> RUN when it rises again.
  - In WAIT_CAL and HALT: UpCommandReady = 0. An already-registered DRAMCommandValid is held until accepted. FIFO drain and read return continue.
- Command stage:
  - Single output register. UpCommandReady = (state == RUN) & (!DRAMCommandValid | DRAMCommandReady) & gate.
  - Write gate: credits > 0.
  - Read gate: OutReads + pending < MaxOutReads, where pending counts a read held in the output register.
  - Unknown command codes are treated as reads.
  - Up handshake loads the register, giving 1 cycle latency Up -> DRAM.
  - Valid stays asserted and fields stay stable until DRAMCommandReady.
- Write credits:
  - +1 on Up write-data handshake; -1 on Up write-command handshake. Simultaneous +1/-1 leaves the count unchanged.
  - Width is log2(WrFIFODepth)+1.
  - A write command is therefore never issued ahead of its data.
- Write FIFO:
  - UpWriteDataReady = !full. Push on valid & ready.
  - DRAMWriteDataValid = !empty, with data/mask from the FIFO head (first-word fall-through). Pop on valid & DRAMWriteDataReady.
  - Push and pop in the same cycle while full: pop frees a slot, but ready is computed from the registered full flag, so the push is not accepted.
  - Pointers wrap modulo WrFIFODepth.
- Read return:
  - UpReadData/UpReadDataValid are registered copies of DRAMReadData/DRAMReadDataValid, giving 1 cycle latency.
  - OutReads: +1 on a DRAM read-command handshake; -1 on DRAMReadDataValid; both in the same cycle leaves it unchanged.
  - DRAMReadDataValid while OutReads == 0: set ErrorReadUnderflow (sticky until reset), still forward the data, and keep the counter at 0.

Optional Feature:
- DRAM_SHIM_STATS_EN defined:
  - Adds outputs StatReads[31:0], StatWrites[31:0] and StatStallCycles[31:0], reset to 0.
  - StatReads/StatWrites increment on DRAM command handshakes.
  - StatStallCycles increments each cycle DRAMCommandValid & !DRAMCommandReady.
  - All three saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (DDR3SDRAMLocal.vh): DDRCWidth/DDRAWidth/DDRDWidth/DDRMWidth and the command encodings DDR3CMD_Write/DDR3CMD_Read.
- FSM state encodings stay local to the block.
- One natural sub-module: shim_fifo, a parameterised first-word fall-through FIFO with full/empty flags, used for write data+mask.

Test Plan:
- Hold CalibrationComplete = 0 for 50 cycles while presenting a read -> UpCommandReady stays 0. Raise it -> DRAMCommandValid asserts 1 cycle after the Up handshake with matching address 28'h0000040.
- Send a write command with no data -> UpCommandReady = 0. Push one beat of 512'hA5.. -> command accepted next cycle, and DRAMWriteData = A5.. is valid no later than DRAMCommandValid.
- Issue 32 reads with the MIG never returning data -> the 33rd read is blocked and OutReads = 32. Return one beat -> the 33rd is accepted and UpReadData matches 1 cycle after DRAMReadDataValid.
- Hold DRAMWriteDataReady = 0 and push 16 beats -> UpWriteDataReady = 0 at full. Release -> 16 pops in order, with no loss across pointer wrap.
- Pulse DRAMReadDataValid with OutReads = 0 -> ErrorReadUnderflow = 1 and stays set. Assert ResetN = 0 mid-burst -> all outputs clear asynchronously.
- Drop CalibrationComplete while a command is held unaccepted -> that command remains valid until DRAMCommandReady, then no further commands issue until calibration returns.

Source files
------------

// File: rtl/dram_cmd_shim_pkg.sv
// Shared DDR command-side definitions for the DRAM command shim:
// bus widths, MIG command encodings and small helpers.
package dram_cmd_shim_pkg;

  localparam int DDRCWidth = 3;
  localparam int DDRAWidth = 28;
  localparam int DDRDWidth = 512;
  localparam int DDRMWidth = DDRDWidth / 8;

  localparam logic [DDRCWidth-1:0] DDR3CMD_Write = 3'b000;
  localparam logic [DDRCWidth-1:0] DDR3CMD_Read  = 3'b001;

  // Anything that is not an explicit write is handled as a read.
  function automatic logic is_write(input logic [DDRCWidth-1:0] cmd);
    return cmd == DDR3CMD_Write;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dram_cmd_shim_fifo.sv
// First-word fall-through FIFO used for the write data+mask path.
// push_ready is a registered !full, so a pop into a full FIFO frees a slot
// only from the next cycle on.
module dram_cmd_shim_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [Width-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             push, pop;

  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];
  assign push      = push_valid & push_ready;
  assign pop       = pop_valid & pop_ready;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // Pointers wrap naturally at AW bits since Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      push_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      push_ready <= (count_next != (AW+1)'(Depth));
    end
  end

  // Storage carries no reset; contents are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dram_cmd_shim.sv
// DRAM command shim between the ORAM core and the MIG.
// Writes wait for credits from the write-data FIFO so data never trails
// its command; reads are throttled by an outstanding-read limit; nothing
// issues until calibration completes.
// Optional: define DRAM_SHIM_STATS_EN for saturating command/stall counters.
module dram_cmd_shim
  import dram_cmd_shim_pkg::*;
#(
  parameter int WrFIFODepth = 16,
  parameter int MaxOutReads = 32,
  localparam int OutW  = $clog2(MaxOutReads) + 1,
  localparam int CredW = $clog2(WrFIFODepth) + 1
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 CalibrationComplete,
  input  logic [DDRCWidth-1:0] UpCommand,
  input  logic [DDRAWidth-1:0] UpAddress,
  input  logic                 UpCommandValid,
  output logic                 UpCommandReady,
  input  logic [DDRDWidth-1:0] UpWriteData,
  input  logic [DDRMWidth-1:0] UpWriteMask,
  input  logic                 UpWriteDataValid,
  output logic                 UpWriteDataReady,
  output logic [DDRDWidth-1:0] UpReadData,
  output logic                 UpReadDataValid,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic [DDRAWidth-1:0] DRAMAddress,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMWriteData,
  output logic [DDRMWidth-1:0] DRAMWriteMask,
  output logic                 DRAMWriteDataValid,
  input  logic                 DRAMWriteDataReady,
  input  logic [DDRDWidth-1:0] DRAMReadData,
  input  logic                 DRAMReadDataValid,
  output logic [OutW-1:0]      OutReads,
  output logic                 ErrorReadUnderflow
`ifdef DRAM_SHIM_STATS_EN
  ,
  output logic [31:0]          StatReads,
  output logic [31:0]          StatWrites,
  output logic [31:0]          StatStallCycles
`endif
);

  typedef enum logic [1:0] {WAIT_CAL, RUN, HALT} state_t;

  state_t           state;
  logic [CredW-1:0] credits;
  logic [OutW:0]    reads_committed;
  logic             up_is_write, held_read, read_gate, write_gate;
  logic             up_cmd_fire, dram_cmd_fire, wr_data_fire, wr_cmd_fire, rd_issue;

  // Calibration gate: commands only enter while calibrated.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= WAIT_CAL;
    else begin
      case (state)
        WAIT_CAL: if (CalibrationComplete)  state <= RUN;
        RUN:      if (!CalibrationComplete) state <= HALT;
        HALT:     if (CalibrationComplete)  state <= RUN;
        default:  state <= WAIT_CAL;
      endcase
    end
  end

  // A read sitting in the output register already counts against the limit.
  assign up_is_write     = is_write(UpCommand);
  assign held_read       = DRAMCommandValid & ~is_write(DRAMCommand);
  assign reads_committed = {1'b0, OutReads} + {{OutW{1'b0}}, held_read};
  assign read_gate       = reads_committed < (OutW+1)'(MaxOutReads);
  assign write_gate      = (credits != '0);

  assign UpCommandReady = (state == RUN) & (~DRAMCommandValid | DRAMCommandReady) &
                          (up_is_write ? write_gate : read_gate);

  assign up_cmd_fire   = UpCommandValid & UpCommandReady;
  assign dram_cmd_fire = DRAMCommandValid & DRAMCommandReady;
  assign wr_data_fire  = UpWriteDataValid & UpWriteDataReady;
  assign wr_cmd_fire   = up_cmd_fire & up_is_write;
  assign rd_issue      = dram_cmd_fire & ~is_write(DRAMCommand);

  // Command output valid: set on Up handshake, held until the MIG takes it.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)            DRAMCommandValid <= 1'b0;
    else if (up_cmd_fire)   DRAMCommandValid <= 1'b1;
    else if (dram_cmd_fire) DRAMCommandValid <= 1'b0;
  end

  // Command payload; only loads on handshake so it is stable while held.
  always_ff @(posedge Clock) begin
    if (up_cmd_fire) begin
      DRAMCommand <= UpCommand;
      DRAMAddress <= UpAddress;
    end
  end

  // Write credits: one per buffered beat not yet claimed by a command.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) credits <= '0;
    else if (wr_data_fire && !wr_cmd_fire) credits <= credits + 1'b1;
    else if (!wr_data_fire && wr_cmd_fire) credits <= credits - 1'b1;
  end

  // Outstanding reads and sticky underflow on unsolicited return data.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      OutReads           <= '0;
      ErrorReadUnderflow <= 1'b0;
    end else begin
      if (rd_issue && !DRAMReadDataValid) OutReads <= OutReads + 1'b1;
      else if (!rd_issue && DRAMReadDataValid && OutReads != '0)
        OutReads <= OutReads - 1'b1;
      if (DRAMReadDataValid && OutReads == '0) ErrorReadUnderflow <= 1'b1;
    end
  end

  // Read return valid, one cycle behind the MIG.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) UpReadDataValid <= 1'b0;
    else         UpReadDataValid <= DRAMReadDataValid;
  end

  // Read return data; no reset needed on the payload.
  always_ff @(posedge Clock) begin
    UpReadData <= DRAMReadData;
  end

  dram_cmd_shim_fifo #(
    .Width (DDRDWidth + DDRMWidth),
    .Depth (WrFIFODepth)
  ) u_wr_fifo (
    .clk        (Clock),
    .rst_n      (ResetN),
    .push_data  ({UpWriteMask, UpWriteData}),
    .push_valid (UpWriteDataValid),
    .push_ready (UpWriteDataReady),
    .pop_data   ({DRAMWriteMask, DRAMWriteData}),
    .pop_valid  (DRAMWriteDataValid),
    .pop_ready  (DRAMWriteDataReady)
  );

`ifdef DRAM_SHIM_STATS_EN
  // Saturating statistics on MIG-side command traffic.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      StatReads       <= '0;
      StatWrites      <= '0;
      StatStallCycles <= '0;
    end else begin
      if (rd_issue) StatReads <= sat_inc32(StatReads);
      if (dram_cmd_fire && is_write(DRAMCommand)) StatWrites <= sat_inc32(StatWrites);
      if (DRAMCommandValid && !DRAMCommandReady)
        StatStallCycles <= sat_inc32(StatStallCycles);
    end
  end
`endif

endmodule
